// File: rtl/md_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state encodings and the iteration-counter width helper.
package md_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_OP_MUL    = 3'b000,
        MD_OP_MULH   = 3'b001,
        MD_OP_MULHSU = 3'b010,
        MD_OP_MULHU  = 3'b011,
        MD_OP_DIV    = 3'b100,
        MD_OP_DIVU   = 3'b101,
        MD_OP_REM    = 3'b110,
        MD_OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'b00,
        MD_ST_CALC = 2'b01,
        MD_ST_FIX  = 2'b10,
        MD_ST_DONE = 2'b11
    } md_state_e;

    // One extra bit so the counter can hold DATA_WIDTH itself.
    function automatic int md_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration of the shared datapath: shift-add multiply
// (i_mode=0) or restoring divide (i_mode=1) over a {high,low} accumulator.
module md_iter_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_mode,
    input  logic [2*DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0]   i_opb,
    output logic [2*DATA_WIDTH-1:0] o_acc
);
    localparam int W = DATA_WIDTH;

    logic [W:0]   w_sum;
    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_rem_sub;

    always_comb begin
        w_sum     = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opb} : '0);
        // Remainder is always below the divisor, so the trial difference fits W bits.
        w_shift   = {i_acc[2*W-1:W], i_acc[W-1]};
        w_ge      = (w_shift >= {1'b0, i_opb});
        w_rem_sub = w_shift[W-1:0] - i_opb;
        if (i_mode) begin
            o_acc = {(w_ge ? w_rem_sub : w_shift[W-1:0]), i_acc[W-2:0], w_ge};
        end else begin
            o_acc = {w_sum, i_acc[W-1:1]};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer, one result bit per cycle.
//   state | meaning
//   IDLE  | waiting for start_i; special cases resolve straight to DONE
//   CALC  | DATA_WIDTH iterations of md_iter_step
//   FIX   | sign correction and half select into result_o
//   DONE  | done_o pulse, busy_o still high
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] s1_i,
    input  logic [DATA_WIDTH-1:0] s2_i,
    input  logic                  kill_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = md_cnt_width(DATA_WIDTH);

    md_state_e         r_state;
    md_op_e            r_op;
    logic              r_neg;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*W-1:0]    r_acc;
    logic [W-1:0]      r_opb;
    logic              r_busy;
    logic              r_done;
    logic [W-1:0]      r_result;

    md_op_e            w_op;
    logic              w_s1_signed;
    logic              w_s2_signed;
    logic              w_s1_neg;
    logic              w_s2_neg;
    logic [W-1:0]      w_s1_mag;
    logic [W-1:0]      w_s2_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic [W-1:0]      w_special_res;
    logic              w_neg_flag;
    logic [2*W-1:0]    w_step;
    logic [2*W-1:0]    w_acc_neg;
    logic [2*W-1:0]    w_prod;
    logic [W-1:0]      w_quo;
    logic [W-1:0]      w_rem;
    logic [W-1:0]      w_fix;

    md_iter_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .i_mode(r_op[2]),
        .i_acc (r_acc),
        .i_opb (r_opb),
        .o_acc (w_step)
    );

    always_comb begin
        w_op        = md_op_e'(op_i);
        w_s1_signed = (w_op != MD_OP_MULHU) && (w_op != MD_OP_DIVU) && (w_op != MD_OP_REMU);
        w_s2_signed = (w_op == MD_OP_MUL) || (w_op == MD_OP_MULH) ||
                      (w_op == MD_OP_DIV) || (w_op == MD_OP_REM);
        w_s1_neg    = w_s1_signed && s1_i[W-1];
        w_s2_neg    = w_s2_signed && s2_i[W-1];
        w_s1_mag    = w_s1_neg ? -s1_i : s1_i;
        w_s2_mag    = w_s2_neg ? -s2_i : s2_i;
        w_div_zero  = op_i[2] && (s2_i == '0);
        w_ovf       = ((w_op == MD_OP_DIV) || (w_op == MD_OP_REM)) &&
                      (s1_i == {1'b1, {(W-1){1'b0}}}) && (s2_i == '1);
        // op_i[1] distinguishes REM/REMU from DIV/DIVU.
        if (w_div_zero) begin
            w_special_res = op_i[1] ? s1_i : '1;
        end else begin
            w_special_res = op_i[1] ? '0 : s1_i;
        end
        w_neg_flag  = (op_i[2] && op_i[1]) ? w_s1_neg : (w_s1_neg ^ w_s2_neg);
    end

    always_comb begin
        w_acc_neg = -r_acc;
        w_prod    = r_neg ? w_acc_neg : r_acc;
        w_quo     = r_acc[W-1:0];
        w_rem     = r_acc[2*W-1:W];
        if (!r_op[2]) begin
            w_fix = (r_op == MD_OP_MUL) ? w_prod[W-1:0] : w_prod[2*W-1:W];
        end else if (r_op[1]) begin
            w_fix = r_neg ? -w_rem : w_rem;
        end else begin
            w_fix = r_neg ? -w_quo : w_quo;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= MD_ST_IDLE;
            r_op     <= MD_OP_MUL;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                MD_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i && !kill_i) begin
                        r_op   <= w_op;
                        r_neg  <= w_neg_flag;
                        r_busy <= 1'b1;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= MD_ST_DONE;
                        end else begin
                            r_acc   <= {{W{1'b0}}, w_s1_mag};
                            r_opb   <= w_s2_mag;
                            r_cnt   <= '0;
                            r_state <= MD_ST_CALC;
                        end
                    end
                end
                MD_ST_CALC: begin
                    if (kill_i) begin
                        r_busy  <= 1'b0;
                        r_state <= MD_ST_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            r_state <= MD_ST_FIX;
                        end
                    end
                end
                MD_ST_FIX: begin
                    if (kill_i) begin
                        r_busy  <= 1'b0;
                        r_state <= MD_ST_IDLE;
                    end else begin
                        r_result <= w_fix;
                        r_done   <= 1'b1;
                        r_state  <= MD_ST_DONE;
                    end
                end
                MD_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= MD_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= MD_ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus pushes model results, a
// negedge monitor pops them on every done_o pulse.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk_i   = 1'b0;
    logic         rstn_i  = 1'b0;
    logic         start_i = 1'b0;
    logic         kill_i  = 1'b0;
    logic [2:0]   op_i    = 3'b000;
    logic [W-1:0] s1_i    = '0;
    logic [W-1:0] s2_i    = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;

    md_sequencer #(.DATA_WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (start_i),
        .op_i    (op_i),
        .s1_i    (s1_i),
        .s2_i    (s2_i),
        .kill_i  (kill_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           checks      = 0;
    int           failures    = 0;
    int           done_cnt    = 0;
    logic [W-1:0] last_result = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: full-width integer arithmetic with the RISC-V corner rules.
    function automatic logic [W-1:0] ref_md(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint          sa;
        longint          sb;
        longint          ps;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_OP_MUL:    begin ps = sa * sb;           return ps[31:0];  end
            MD_OP_MULH:   begin ps = sa * sb;           return ps[63:32]; end
            MD_OP_MULHSU: begin ps = sa * longint'(ub); return ps[63:32]; end
            MD_OP_MULHU:  begin pu = ua * ub;           return pu[63:32]; end
            MD_OP_DIV: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                ps = sa / sb;
                return ps[31:0];
            end
            MD_OP_DIVU: begin
                if (b == 0) return '1;
                pu = ua / ub;
                return pu[31:0];
            end
            MD_OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                ps = sa % sb;
                return ps[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub;
                return pu[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit is_div;
        bit ovf;
        is_div = (op >= 3'd4);
        ovf    = (op == MD_OP_DIV || op == MD_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        return (is_div && (b == 0 || ovf)) ? 1 : W + 2;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    check("done_without_op", W'(done_o), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", result_o, mon_e.res);
                    check("latency", W'(cyc - mon_e.acc_cyc + 1), W'(mon_e.lat));
                    check("busy_in_done", W'(busy_o), 32'd1);
                    last_result = mon_e.res;
                    done_cnt++;
                end
            end else if (sb_q.size() > 0 && cyc >= sb_q[0].acc_cyc) begin
                check("busy_hold", W'(busy_o), 32'd1);
            end
        end
    end

    // pulse_at/kill_at/rst_at: loop index (cycle-1 after accept) for extra events, -1 = none.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at, input int kill_at, input int rst_at);
        int   prev;
        bit   seen;
        exp_t e;
        @(negedge clk_i); #1;
        check("idle_busy", W'(busy_o), 32'd0);
        check("result_hold", result_o, last_result);
        op_i    = op;
        s1_i    = a;
        s2_i    = b;
        start_i = 1'b1;
        e.res     = ref_md(op, a, b);
        e.lat     = ref_lat(op, a, b);
        e.acc_cyc = cyc + 1;
        if (kill_at < 0) sb_q.push_back(e);
        prev = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i); #1;
            if (i == 0 || (pulse_at >= 0 && i == pulse_at + 1)) begin
                start_i = 1'b0;
                op_i    = 3'($urandom);
                s1_i    = W'($urandom);
                s2_i    = W'($urandom);
            end
            if (pulse_at > 0 && i == pulse_at) start_i = 1'b1;
            if (kill_at >= 0 && i == kill_at) kill_i = 1'b1;
            if (kill_at >= 0 && i == kill_at + 1) begin
                kill_i = 1'b0;
                check("kill_busy", W'(busy_o), 32'd0);
                check("kill_result", result_o, last_result);
                seen = 1'b1;
            end
            if (rst_at >= 0 && i == rst_at) begin
                #2 rstn_i = 1'b0;
                #1;
                check("rst_busy", W'(busy_o), 32'd0);
                check("rst_done", W'(done_o), 32'd0);
                check("rst_result", result_o, 32'd0);
                sb_q.delete();
                last_result = '0;
                @(negedge clk_i); #1 rstn_i = 1'b1;
                seen = 1'b1;
            end
            if (done_cnt != prev) seen = 1'b1;
        end
        if (kill_at >= 0) begin
            repeat (40) @(negedge clk_i);
            #1 check("kill_no_done", W'(done_cnt), W'(prev));
        end else if (rst_at < 0) begin
            check("done_seen", W'(done_cnt), W'(prev + 1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        @(negedge clk_i); #1;
        check("reset_busy", W'(busy_o), 32'd0);
        check("reset_done", W'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        rstn_i = 1'b1;

        run_op(MD_OP_MUL,    32'd7,          32'hFFFF_FFFD, -1, -1, -1);
        run_op(MD_OP_MULH,   32'd7,          32'hFFFF_FFFD, -1, -1, -1);
        run_op(MD_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, -1, -1);
        run_op(MD_OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, -1, -1);
        run_op(MD_OP_DIV,    32'hFFFF_FFEC,  32'd6,         -1, -1, -1);
        run_op(MD_OP_REM,    32'hFFFF_FFEC,  32'd6,         -1, -1, -1);
        run_op(MD_OP_DIVU,   32'd100,        32'd7,         -1, -1, -1);
        run_op(MD_OP_REMU,   32'd100,        32'd7,         -1, -1, -1);
        run_op(MD_OP_DIVU,   32'd5,          32'd0,         -1, -1, -1);
        run_op(MD_OP_REM,    32'd5,          32'd0,         -1, -1, -1);
        run_op(MD_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, -1, -1, -1);
        run_op(MD_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, -1, -1, -1);
        run_op(MD_OP_MUL,    32'd0,          32'h1234_5678, -1, -1, -1);

        run_op(MD_OP_DIV,    32'd1000,       32'd7,          9, -1, -1);
        run_op(MD_OP_DIV,    32'hDEAD_BEEF,  32'd13,        -1, 14, -1);
        run_op(MD_OP_MUL,    32'h0001_2345,  32'h0000_0777, -1, -1, 19);
        run_op(MD_OP_MUL,    32'h0001_2345,  32'h0000_0777, -1, -1, -1);

        @(negedge clk_i); #1;
        prev    = done_cnt;
        op_i    = MD_OP_DIVU;
        s1_i    = 32'd9;
        s2_i    = 32'd3;
        start_i = 1'b1;
        kill_i  = 1'b1;
        @(negedge clk_i); #1;
        start_i = 1'b0;
        kill_i  = 1'b0;
        check("killstart_busy", W'(busy_o), 32'd0);
        repeat (3) @(negedge clk_i);
        #1 check("killstart_no_done", W'(done_cnt), W'(prev));

        repeat (40) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), -1, -1, -1);
        end

        repeat (2) @(negedge clk_i);
        check("queue_empty", W'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
